midi_uart_rx_core: RTL and testbench



---
 rtl/midi_pkg.sv | 20 ++
 rtl/baud_tick_gen.sv | 30 +++
 rtl/midi_uart_rx_core.sv | 90 +++++++++
 tb/tb_midi_uart_rx_core.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/midi_pkg.sv
// Shared types and constants for the MIDI serial input path.
// Receiver state encoding, oversampling geometry and default baud-tick settings.
package midi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_t;

  localparam int OVERSAMPLE = 16;
  localparam int MID_SAMPLE = 7;
  localparam int DATA_BITS  = 8;

  // 50 MHz / (99 + 1) = 500 kHz = 16 x 31 250 baud
  localparam logic [15:0] DEF_BAUD_FREQ  = 16'd1;
  localparam logic [15:0] DEF_BAUD_LIMIT = 16'd99;

endpackage

// File: rtl/baud_tick_gen.sv
// Fractional baud tick: accumulator steps by BAUD_FREQ and wraps at BAUD_LIMIT.
// tick is registered, one cycle wide; free-running, no backpressure.
module baud_tick_gen
  import midi_pkg::*;
#(
  parameter logic [15:0] BAUD_FREQ  = DEF_BAUD_FREQ,
  parameter logic [15:0] BAUD_LIMIT = DEF_BAUD_LIMIT
) (
  input  logic clk,
  input  logic res,
  output logic tick
);

  logic [15:0] acc;

  always_ff @(posedge clk) begin
    if (res) begin
      acc  <= 16'd0;
      tick <= 1'b0;
    // a zero increment must stay silent even when the limit is zero
    end else if ((BAUD_FREQ != 16'd0) && (acc >= BAUD_LIMIT)) begin
      acc  <= acc - BAUD_LIMIT;
      tick <= 1'b1;
    end else begin
      acc  <= acc + BAUD_FREQ;
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/midi_uart_rx_core.sv
// 8N1 MIDI receiver, 16x oversampled; DATA/DATA_VALID one cycle after the mid-stop-bit tick
// (~152 ticks after the start edge). No backpressure: each byte is a single-cycle strobe.
module midi_uart_rx_core
  import midi_pkg::*;
#(
  parameter logic [15:0] BAUD_FREQ  = DEF_BAUD_FREQ,
  parameter logic [15:0] BAUD_LIMIT = DEF_BAUD_LIMIT
) (
  input  logic       CLK,
  input  logic       RES,
  input  logic       MIDI_IN,
  output logic [7:0] DATA,
  output logic       DATA_VALID
);

  localparam logic [3:0] MID_TICK  = 4'(MID_SAMPLE);
  localparam logic [3:0] LAST_TICK = 4'(OVERSAMPLE - 1);
  localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);

  logic       tick;
  logic [1:0] sync_q;
  logic       rx;
  rx_state_t  state;
  rx_state_t  state_nxt;
  logic [3:0] tick_cnt;
  logic [2:0] bit_cnt;
  logic [7:0] shreg;
  logic       sample_bit;
  logic       load;

  baud_tick_gen #(
    .BAUD_FREQ (BAUD_FREQ),
    .BAUD_LIMIT(BAUD_LIMIT)
  ) u_tick (
    .clk (CLK),
    .res (RES),
    .tick(tick)
  );

  assign rx = sync_q[1];

  always_ff @(posedge CLK) begin
    if (RES) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (tick) begin
      case (state)
        ST_IDLE:  if (!rx) state_nxt = ST_START;
        ST_START: if (tick_cnt == MID_TICK) state_nxt = rx ? ST_IDLE : ST_DATA;
        ST_DATA:  if ((tick_cnt == LAST_TICK) && (bit_cnt == LAST_BIT)) state_nxt = ST_STOP;
        // leave at mid stop bit so a back-to-back start edge is not missed
        ST_STOP:  if (tick_cnt == LAST_TICK) state_nxt = ST_IDLE;
        default:  state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    sample_bit = tick && (state == ST_DATA) && (tick_cnt == LAST_TICK);
    load       = tick && (state == ST_STOP) && (tick_cnt == LAST_TICK) && rx;
  end

  always_ff @(posedge CLK) begin
    if (RES) begin
      sync_q     <= 2'b11;
      tick_cnt   <= 4'd0;
      bit_cnt    <= 3'd0;
      shreg      <= 8'd0;
      DATA       <= 8'd0;
      DATA_VALID <= 1'b0;
    end else begin
      sync_q     <= {sync_q[0], MIDI_IN};
      DATA_VALID <= load;
      if (load) DATA <= shreg;
      if (tick) begin
        if ((state == ST_IDLE) || (state != state_nxt)) tick_cnt <= 4'd0;
        else                                            tick_cnt <= tick_cnt + 4'd1;
        if (state == ST_START) bit_cnt <= 3'd0;
        if (sample_bit) begin
          shreg   <= {rx, shreg[7:1]};
          bit_cnt <= bit_cnt + 3'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_midi_uart_rx_core.sv
// Directed bench: default-rate instance for tick/latency, 2/198 instance for the
// fractional tick, and a 10x faster instance (tick every 10 cycles) for framing scenarios.
module tb_midi_uart_rx_core;

  logic       clk = 1'b0;
  logic       res = 1'b1;
  logic       midi_a = 1'b1;
  logic       midi_b = 1'b1;
  logic       midi_f = 1'b1;
  logic [7:0] data_a, data_b, data_f;
  logic       vld_a, vld_b, vld_f;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int start_cyc = 0;
  int cnt_a = 0;
  int cnt_f = 0;
  int vld_cyc_a = 0;
  int dbl = 0;
  logic prev_a = 1'b0;
  logic prev_f = 1'b0;
  logic [7:0] got_f[$];

  always #10 clk = ~clk;

  midi_uart_rx_core u_dut (
    .CLK(clk), .RES(res), .MIDI_IN(midi_a), .DATA(data_a), .DATA_VALID(vld_a)
  );

  midi_uart_rx_core #(.BAUD_FREQ(16'd2), .BAUD_LIMIT(16'd198)) u_dut2 (
    .CLK(clk), .RES(res), .MIDI_IN(midi_b), .DATA(data_b), .DATA_VALID(vld_b)
  );

  midi_uart_rx_core #(.BAUD_FREQ(16'd1), .BAUD_LIMIT(16'd9)) u_fast (
    .CLK(clk), .RES(res), .MIDI_IN(midi_f), .DATA(data_f), .DATA_VALID(vld_f)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (vld_a) begin
      cnt_a++;
      vld_cyc_a = cyc;
    end
    if (vld_f) begin
      cnt_f++;
      got_f.push_back(data_f);
    end
    if ((vld_a && prev_a) || (vld_f && prev_f)) dbl++;
    prev_a = vld_a;
    prev_f = vld_f;
  end

  task automatic send_bit(input logic fast, input logic v, input int n);
    if (fast) midi_f = v;
    else      midi_a = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic fast, input logic [7:0] b, input logic stop);
    int bc;
    bc = fast ? 160 : 1600;
    start_cyc = cyc;
    send_bit(fast, 1'b0, bc);
    for (int i = 0; i < 8; i++) send_bit(fast, b[i], bc);
    send_bit(fast, stop, bc);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_checks++;
    if (data_a !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h expected 00", data_a); end
    n_checks++;
    if (vld_a !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", vld_a); end
    n_checks++;
    if (data_f !== 8'h00) begin n_fail++; $display("FAIL reset_data_fast: got %h expected 00", data_f); end
    n_checks++;
    if (u_dut.u_tick.tick !== 1'b0) begin n_fail++; $display("FAIL reset_tick: got %b expected 0", u_dut.u_tick.tick); end
  endtask

  task automatic test_tick();
    int n;
    int t;
    res = 1'b0;
    n = 0;
    while (n < 300) begin
      @(negedge clk);
      n++;
      if (u_dut.u_tick.tick === 1'b1) break;
    end
    n_checks++;
    if (n != 100) begin n_fail++; $display("FAIL first_tick: got %0d cycles expected 100", n); end
    n = 0;
    while (n < 300) begin
      @(negedge clk);
      n++;
      if (u_dut.u_tick.tick === 1'b1) break;
    end
    n_checks++;
    if (n != 100) begin n_fail++; $display("FAIL tick_period: got %0d cycles expected 100", n); end
    t = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (u_dut2.u_tick.tick === 1'b1) t++;
    end
    n_checks++;
    if (t != 10) begin n_fail++; $display("FAIL frac_tick_count: got %0d ticks in 1000 cycles expected 10", t); end
  endtask

  task automatic test_single_byte();
    int base;
    int lat;
    base = cnt_a;
    send_byte(1'b0, 8'h90, 1'b1);
    repeat (200) @(negedge clk);
    lat = vld_cyc_a - start_cyc;
    n_checks++;
    if (cnt_a - base != 1) begin n_fail++; $display("FAIL single_count: got %0d pulses expected 1", cnt_a - base); end
    n_checks++;
    if (data_a !== 8'h90) begin n_fail++; $display("FAIL single_data: got %h expected 90", data_a); end
    n_checks++;
    if (lat < 15200 || lat > 15310) begin n_fail++; $display("FAIL single_latency: got %0d cycles expected 15200..15310", lat); end
  endtask

  task automatic test_back_to_back();
    int base;
    logic [7:0] exp_b [3];
    exp_b[0] = 8'h90; exp_b[1] = 8'h3C; exp_b[2] = 8'h64;
    got_f.delete();
    base = cnt_f;
    for (int i = 0; i < 3; i++) send_byte(1'b1, exp_b[i], 1'b1);
    repeat (400) @(negedge clk);
    n_checks++;
    if (cnt_f - base != 3) begin n_fail++; $display("FAIL b2b_count: got %0d pulses expected 3", cnt_f - base); end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (got_f.size() <= i) begin
        n_fail++; $display("FAIL b2b_byte%0d: got none expected %h", i, exp_b[i]);
      end else if (got_f[i] !== exp_b[i]) begin
        n_fail++; $display("FAIL b2b_byte%0d: got %h expected %h", i, got_f[i], exp_b[i]);
      end
    end
  endtask

  task automatic test_glitch();
    int base;
    base = cnt_f;
    send_bit(1'b1, 1'b0, 20);
    send_bit(1'b1, 1'b1, 1000);
    n_checks++;
    if (cnt_f - base != 0) begin n_fail++; $display("FAIL glitch_pulse: got %0d pulses expected 0", cnt_f - base); end
    send_byte(1'b1, 8'h45, 1'b1);
    send_bit(1'b1, 1'b1, 400);
    n_checks++;
    if (cnt_f - base != 1) begin n_fail++; $display("FAIL glitch_next_count: got %0d pulses expected 1", cnt_f - base); end
    n_checks++;
    if (data_f !== 8'h45) begin n_fail++; $display("FAIL glitch_next_data: got %h expected 45", data_f); end
  endtask

  task automatic test_framing();
    int base;
    base = cnt_f;
    send_byte(1'b1, 8'h80, 1'b0);
    send_bit(1'b1, 1'b1, 500);
    n_checks++;
    if (cnt_f - base != 0) begin n_fail++; $display("FAIL frame_err_pulse: got %0d pulses expected 0", cnt_f - base); end
    n_checks++;
    if (data_f !== 8'h45) begin n_fail++; $display("FAIL frame_err_hold: got %h expected 45", data_f); end
    send_byte(1'b1, 8'h7F, 1'b1);
    send_bit(1'b1, 1'b1, 400);
    n_checks++;
    if (cnt_f - base != 1) begin n_fail++; $display("FAIL frame_next_count: got %0d pulses expected 1", cnt_f - base); end
    n_checks++;
    if (data_f !== 8'h7F) begin n_fail++; $display("FAIL frame_next_data: got %h expected 7f", data_f); end
  endtask

  task automatic test_reset_midframe();
    int base;
    logic [7:0] b;
    b = 8'hB0;
    base = cnt_f;
    send_bit(1'b1, 1'b0, 160);
    for (int i = 0; i < 4; i++) send_bit(1'b1, b[i], 160);
    send_bit(1'b1, b[4], 80);
    res = 1'b1;
    @(negedge clk);
    res = 1'b0;
    n_checks++;
    if (data_f !== 8'h00) begin n_fail++; $display("FAIL midreset_data: got %h expected 00", data_f); end
    send_bit(1'b1, 1'b1, 2000);
    n_checks++;
    if (cnt_f - base != 0) begin n_fail++; $display("FAIL midreset_pulse: got %0d pulses expected 0", cnt_f - base); end
    n_checks++;
    if (data_f !== 8'h00) begin n_fail++; $display("FAIL midreset_hold: got %h expected 00", data_f); end
    send_byte(1'b1, 8'hE0, 1'b1);
    send_bit(1'b1, 1'b1, 400);
    n_checks++;
    if (cnt_f - base != 1) begin n_fail++; $display("FAIL midreset_next_count: got %0d pulses expected 1", cnt_f - base); end
    n_checks++;
    if (data_f !== 8'hE0) begin n_fail++; $display("FAIL midreset_next_data: got %h expected e0", data_f); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_tick();
    test_single_byte();
    test_back_to_back();
    test_glitch();
    test_framing();
    test_reset_midframe();
    n_checks++;
    if (dbl != 0) begin n_fail++; $display("FAIL valid_width: got %0d double-cycle pulses expected 0", dbl); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
